// File: rtl/hpi_keycode_poller.sv
// -----------------------------------------------------------------------------
// hpi_keycode_poller
//
// Hardware HPI bus master for the EZ-OTG host port. Replaces software PIO
// bit-banging of the HPI address/cs/rd/wr lines. A free-running poll timer
// periodically triggers a burst that rewrites the HPI ADDRESS register with
// KEY_BASE and then reads NUM_WORDS keycode words through the auto-incrementing
// DATA register. The words land in a shadow buffer and are committed to the
// keycode output in one clock, so game logic never sees a torn burst.
// Single CPU register accesses share the same bus; a pending poll has priority.
//
// Ports
//   clk_clk, reset_reset   clock, asynchronous active-high reset
//   poll_en                enables the periodic poll timer
//   cpu_req/we/addr/wdata  CPU access request (held until cpu_ack)
//   cpu_rdata, cpu_ack     CPU read data and one-cycle completion pulse
//   hpi_addr/cs_n/rd_n/wr_n, hpi_dout/oe, hpi_din   HPI pad interface
//   keycode                last committed burst, word i at [16i+15:16i]
//   keycode_update         one-cycle pulse when a commit changes keycode
//   busy                   FSM is not in IDLE
// -----------------------------------------------------------------------------
module hpi_keycode_poller #(
  parameter int          NUM_WORDS       = 2,
  parameter logic [15:0] KEY_BASE        = 16'h051E,
  parameter int          POLL_CYCLES     = 500000,
  parameter int          ACCESS_CYCLES   = 4,
  parameter int          RECOVERY_CYCLES = 2
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  input  logic                      poll_en,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [1:0]                cpu_addr,
  input  logic [15:0]               cpu_wdata,
  output logic [15:0]               cpu_rdata,
  output logic                      cpu_ack,
  output logic [1:0]                hpi_addr,
  output logic                      hpi_cs_n,
  output logic                      hpi_rd_n,
  output logic                      hpi_wr_n,
  output logic [15:0]               hpi_dout,
  output logic                      hpi_oe,
  input  logic [15:0]               hpi_din,
  output logic [16*NUM_WORDS-1:0]   keycode,
  output logic                      keycode_update,
  output logic                      busy
);

  localparam int TMR_W = $clog2(POLL_CYCLES);
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_CYCLES - 1);
  localparam logic [3:0]       ACC_LAST = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0]       REC_LAST = 4'(RECOVERY_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_ADDR = 2'd2;

  typedef enum logic [2:0] {
    IDLE, CPU_ACC, CPU_REC, ADDR_WR, ADDR_REC, DATA_RD, DATA_REC, COMMIT
  } state_t;

  // One HPI access as launched onto the pads.
  typedef struct packed {
    logic        we;
    logic [1:0]  addr;
    logic [15:0] data;
  } acc_t;

  state_t                       state;
  logic [3:0]                   cnt;
  logic [IDX_W-1:0]             idx;
  logic                         req_we;
  logic [15:0]                  rd_buf;
  logic [NUM_WORDS-1:0][15:0]   shadow;

  logic [TMR_W-1:0]             timer;
  logic                         poll_due;
  logic                         timer_wrap;
  logic                         poll_pending;
  logic                         burst_start;
  logic                         cpu_go;
  logic                         acc_last;
  logic                         rec_last;
  logic                         start_acc;
  acc_t                         nxt_acc;

  // ---------------------------------------------------------------------------
  // Poll timer. The wrap itself counts as a pending poll so that a burst
  // starts exactly POLL_CYCLES clocks after the timer leaves 0; the sticky
  // flag only matters when the wrap lands while the FSM is busy.
  // ---------------------------------------------------------------------------
  assign timer_wrap   = poll_en && (timer == TMR_LAST);
  assign poll_pending = poll_en && (poll_due || timer_wrap);
  assign burst_start  = (state == IDLE) && poll_pending;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      timer    <= '0;
      poll_due <= 1'b0;
    end else if (!poll_en) begin
      timer    <= '0;
      poll_due <= 1'b0;
    end else begin
      timer <= timer_wrap ? '0 : timer + 1'b1;
      if (burst_start)     poll_due <= 1'b0;
      else if (timer_wrap) poll_due <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Access launch decode. cpu_ack blocks a new CPU access in the ack cycle,
  // since the CPU is still holding cpu_req for the access just completed.
  // ---------------------------------------------------------------------------
  assign cpu_go   = cpu_req && !cpu_ack;
  assign acc_last = (cnt == ACC_LAST);
  assign rec_last = (cnt == REC_LAST);

  always_comb begin
    start_acc = 1'b0;
    nxt_acc   = '{we: 1'b0, addr: REG_DATA, data: hpi_dout};
    case (state)
      IDLE: begin
        if (poll_pending) begin
          start_acc = 1'b1;
          nxt_acc   = '{we: 1'b1, addr: REG_ADDR, data: KEY_BASE};
        end else if (cpu_go) begin
          start_acc = 1'b1;
          nxt_acc   = '{we: cpu_we, addr: cpu_addr, data: cpu_wdata};
        end
      end
      ADDR_REC: begin
        start_acc = rec_last;
      end
      DATA_REC: begin
        start_acc = rec_last && (idx != IDX_LAST);
      end
      default: begin
        start_acc = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Main FSM with registered pad strobes. Reset releases the strobes and
  // hpi_oe asynchronously and discards any partial shadow data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      req_we         <= 1'b0;
      rd_buf         <= '0;
      shadow         <= '0;
      hpi_addr       <= '0;
      hpi_cs_n       <= 1'b1;
      hpi_rd_n       <= 1'b1;
      hpi_wr_n       <= 1'b1;
      hpi_oe         <= 1'b0;
      hpi_dout       <= '0;
      cpu_rdata      <= '0;
      cpu_ack        <= 1'b0;
      keycode        <= '0;
      keycode_update <= 1'b0;
    end else begin
      cpu_ack        <= 1'b0;
      keycode_update <= 1'b0;

      if (start_acc) begin
        hpi_addr <= nxt_acc.addr;
        hpi_cs_n <= 1'b0;
        hpi_rd_n <= nxt_acc.we;
        hpi_wr_n <= !nxt_acc.we;
        hpi_oe   <= nxt_acc.we;
        hpi_dout <= nxt_acc.data;
        req_we   <= nxt_acc.we;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (poll_pending) state <= ADDR_WR;
          else if (cpu_go)  state <= CPU_ACC;
        end

        // Strobe phase shared by all three access kinds; read data is
        // sampled on the last low clock while the chip still drives it.
        CPU_ACC, ADDR_WR, DATA_RD: begin
          if (acc_last) begin
            cnt      <= '0;
            hpi_cs_n <= 1'b1;
            hpi_rd_n <= 1'b1;
            hpi_wr_n <= 1'b1;
            hpi_oe   <= 1'b0;
            if (state == CPU_ACC) begin
              state <= CPU_REC;
              if (!req_we) rd_buf <= hpi_din;
            end else if (state == ADDR_WR) begin
              state <= ADDR_REC;
            end else begin
              state       <= DATA_REC;
              shadow[idx] <= hpi_din;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        CPU_REC: begin
          if (rec_last) begin
            cnt     <= '0;
            state   <= IDLE;
            cpu_ack <= 1'b1;
            if (!req_we) cpu_rdata <= rd_buf;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ADDR_REC: begin
          if (rec_last) begin
            cnt   <= '0;
            idx   <= '0;
            state <= DATA_RD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA_REC: begin
          if (rec_last) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              state <= COMMIT;
            end else begin
              idx   <= idx + 1'b1;
              state <= DATA_RD;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Whole-burst commit keeps keycode free of partial updates.
        COMMIT: begin
          keycode        <= shadow;
          keycode_update <= (shadow != keycode);
          state          <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/hpi_keycode_poller.md
Name: hpi_keycode_poller

Overview:
- Hardware HPI bus master for the EZ-OTG USB host port. It replaces software PIO bit-banging of the HPI address, cs, r and w lines.
- It periodically bursts NUM_WORDS keycode words out of OTG memory into a wide keycode register that game logic reads directly.
- It also arbitrates single CPU-issued HPI register accesses into the same bus.
- It sits between the Nios system and the OTG chip pins in the top level.

Parameters:
- NUM_WORDS, 2, number of 16-bit keycode words read per poll burst; legal range 1..8.
- KEY_BASE, 16'h051E, OTG memory address of the first keycode word.
- POLL_CYCLES, 500000, clocks between poll burst starts (10 ms at 50 MHz); must be at least 64.
- ACCESS_CYCLES, 4, clocks each strobe is held low; legal range 2..15.
- RECOVERY_CYCLES, 2, idle clocks with all strobes high after every access; legal range 1..15.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- poll_en  in  1  enables periodic polling.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  2  HPI register: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- cpu_wdata  in  16  write data.
- cpu_rdata  out  16  read data; valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- hpi_addr  out  2  HPI register select.
- hpi_cs_n  out  1  active-low chip select.
- hpi_rd_n  out  1  active-low read strobe.
- hpi_wr_n  out  1  active-low write strobe.
- hpi_dout  out  16  write data to pad.
- hpi_oe  out  1  pad output enable.
- hpi_din  in  16  read data from pad.
- keycode  out  16*NUM_WORDS  last committed burst; word i occupies bits [16i+15:16i].
- keycode_update  out  1  one-cycle pulse when a committed burst differs from the previous one.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:

Reset values:
- hpi_cs_n, hpi_rd_n and hpi_wr_n = 1.
- hpi_oe = 0; hpi_addr, hpi_dout, cpu_rdata and keycode = 0.
- cpu_ack, keycode_update and busy = 0.
- The poll timer clears to 0 and the FSM enters IDLE.
- Assertion of reset during any access releases the strobes and hpi_oe asynchronously. Any partially filled shadow data is discarded.

Poll timer:
- Counts 0..POLL_CYCLES-1 while poll_en = 1, then wraps to 0. The wrap sets a sticky poll_due flag.
- poll_due clears when a burst starts.
- poll_en = 0 holds the timer at 0 and clears poll_due. A burst already in progress completes.

Single access timing (shared by all states):
- hpi_addr is driven and cs_n is low, together with rd_n or wr_n, for exactly ACCESS_CYCLES clocks.
- On writes, hpi_oe = 1 and hpi_dout is stable for those same clocks.
- On reads, hpi_din is registered on the final access clock.
- The access is followed by RECOVERY_CYCLES clocks with all strobes high and hpi_oe = 0.

FSM states:
- IDLE: evaluated every clock.
  - If poll_due, go to ADDR_WR.
  - Else if cpu_req, go to CPU_ACC.
  - When both are pending, the poll wins; cpu_req is served right after the burst.
- CPU_ACC / CPU_REC: one access using cpu_addr, cpu_we and cpu_wdata, sampled on IDLE exit.
  - At the end of recovery, pulse cpu_ack for 1 clock. On reads, cpu_rdata is updated in the same cycle.
  - Return to IDLE.
- ADDR_WR / ADDR_REC: write KEY_BASE to HPI register 2, then go to DATA_RD with word index 0.
- DATA_RD / DATA_REC: read HPI register 0 (the chip auto-increments) into shadow word [index].
  - If index = NUM_WORDS-1, go to COMMIT; otherwise increment the index and repeat.
- COMMIT: one clock.
  - keycode <= shadow.
  - keycode_update = 1 if shadow != previous keycode.
  - Return to IDLE.
  - keycode never shows a partially updated burst.

Other rules:
- Minimum burst length = (NUM_WORDS+1)*(ACCESS_CYCLES+RECOVERY_CYCLES)+1 clocks.
- busy = 1 in every state except IDLE.
- cpu_req dropped before cpu_ack:
  - If the access has not started, no access is issued.
  - If the access has started, it completes and cpu_ack still pulses.
- A CPU write to register 2 between bursts does not corrupt polling, because every burst rewrites ADDRESS first.

Test Plan:
1. Reset mid-DATA_RD: assert reset_reset while hpi_rd_n = 0 -> same cycle hpi_rd_n = 1, hpi_cs_n = 1, hpi_oe = 0. After release, keycode = 0 and the first burst starts POLL_CYCLES clocks later.
2. Poll burst, NUM_WORDS = 2, bench OTG model returns 16'h0004 then 16'h1600 -> the model sees an ADDRESS write of 16'h051E, then two DATA reads. keycode = 32'h1600_0004, keycode_update pulses once, and the burst takes 3*(4+2)+1 = 19 clocks.
3. Unchanged data: repeat the poll with the same model contents -> keycode stays 32'h1600_0004 and keycode_update stays 0.
4. CPU read of STATUS (addr 3), model returns 16'hBEEF -> hpi_rd_n low for exactly 4 clocks with hpi_addr = 3. cpu_ack pulses 2 clocks after the strobe rises, with cpu_rdata = 16'hBEEF.
5. Collision: cpu_req (write 16'h1234 to MAILBOX) rises in the same cycle poll_due sets -> the full poll burst runs first, then a MAILBOX write with hpi_oe = 1 and hpi_dout = 16'h1234, then cpu_ack.
6. poll_en = 0 for 3*POLL_CYCLES -> no HPI strobe activity and busy = 0. After re-enabling, the first burst starts exactly POLL_CYCLES clocks later.
